// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared widths, range-pointer locations and FSM states for the
//               data memory responder and the processor tests.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DMEM_CORE_COUNT  = 4;
  localparam int DMEM_REG_WIDTH   = 12;
  localparam int DMEM_DEPTH       = 4096;
  localparam int DMEM_R_START_LOC = 5;
  localparam int DMEM_R_END_LOC   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    RANGE = 3'd3,
    DUMP  = 3'd4
  } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Single-port RAM, synchronous read with enable; a same-cycle
//               read and write of one address returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int WIDTH      = DMEM_REG_WIDTH * DMEM_CORE_COUNT,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Owns the processor data memory: host image load, processor
//               read/write service, and result-range dump back to the host.
//               Optional macro DUMP_CHECKSUM_EN appends an XOR checksum beat.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int CORE_COUNT          = DMEM_CORE_COUNT,
  parameter int REG_WIDTH           = DMEM_REG_WIDTH,
  parameter int DATA_MEM_DEPTH      = DMEM_DEPTH,
  parameter int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH),
  parameter int R_START_LOC         = DMEM_R_START_LOC,
  parameter int R_END_LOC           = DMEM_R_END_LOC
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0]    dataMemAddr,
  input  logic                              DataMemWrEn,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]   ProcessorDataOut,
  output logic [REG_WIDTH*CORE_COUNT-1:0]   ProcessorDataIn,
  input  logic                              done,
  output logic                              start,
  input  logic                              loadValid,
  output logic                              loadReady,
  input  logic                              loadLast,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]   loadData,
  output logic                              dumpValid,
  input  logic                              dumpReady,
  output logic                              dumpLast,
  output logic [REG_WIDTH*CORE_COUNT-1:0]   dumpData,
  output logic                              busyLoad,
  output logic                              busyRun,
  output logic                              busyDump,
  output logic                              err
);

  localparam int c_WORD_W = REG_WIDTH * CORE_COUNT;
  localparam logic [DATA_MEM_ADDR_WIDTH-1:0] c_LAST_ADDR    = DATA_MEM_ADDR_WIDTH'(DATA_MEM_DEPTH - 1);
  localparam logic [DATA_MEM_ADDR_WIDTH-1:0] c_R_START_ADDR = DATA_MEM_ADDR_WIDTH'(R_START_LOC);
  localparam logic [DATA_MEM_ADDR_WIDTH-1:0] c_R_END_ADDR   = DATA_MEM_ADDR_WIDTH'(R_END_LOC);

  localparam logic [1:0] c_PH_ISSUE = 2'd0;
  localparam logic [1:0] c_PH_DATA  = 2'd1;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [1:0] c_PH_CSUM  = 2'd2;
`endif

  dmem_state_e                    r_state;
  logic [DATA_MEM_ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_MEM_ADDR_WIDTH-1:0] r_ptr;
  logic [DATA_MEM_ADDR_WIDTH-1:0] r_endp;
  logic [1:0]                     r_rcnt;
  logic [1:0]                     r_dphase;
  logic                           r_err;
`ifdef DUMP_CHECKSUM_EN
  logic [c_WORD_W-1:0]            r_csum;
`endif

  logic [DATA_MEM_ADDR_WIDTH-1:0] w_ram_addr;
  logic [c_WORD_W-1:0]            w_ram_wdata;
  logic                           w_ram_we;
  logic                           w_ram_re;
  logic [c_WORD_W-1:0]            w_rdata;
  logic [DATA_MEM_ADDR_WIDTH-1:0] w_lane0_addr;
  logic                           w_load_fire;

  // Range pointers live in lane 0; fit them to the address width.
  generate
    if (REG_WIDTH >= DATA_MEM_ADDR_WIDTH) begin : g_lane0_trunc
      assign w_lane0_addr = w_rdata[DATA_MEM_ADDR_WIDTH-1:0];
    end else begin : g_lane0_ext
      assign w_lane0_addr = {{(DATA_MEM_ADDR_WIDTH-REG_WIDTH){1'b0}}, w_rdata[REG_WIDTH-1:0]};
    end
  endgenerate

  assign loadReady   = (r_state == IDLE) || (r_state == LOAD);
  assign w_load_fire = loadReady && loadValid;

  always_comb begin
    w_ram_addr  = r_cnt;
    w_ram_wdata = loadData;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b1;
    case (r_state)
      IDLE, LOAD: w_ram_we = loadValid;
      RUN: begin
        w_ram_addr  = dataMemAddr;
        w_ram_wdata = ProcessorDataOut;
        w_ram_we    = DataMemWrEn;
      end
      RANGE: w_ram_addr = (r_rcnt == 2'd0) ? c_R_START_ADDR : c_R_END_ADDR;
      DUMP: begin
        w_ram_addr = r_ptr;
        w_ram_re   = (r_dphase == c_PH_ISSUE);
      end
      default: ;
    endcase
    if (rst) begin
      w_ram_we = 1'b0;
    end
  end

  dmem_ram #(
    .WIDTH      (c_WORD_W),
    .DEPTH      (DATA_MEM_DEPTH),
    .ADDR_WIDTH (DATA_MEM_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .addr  (w_ram_addr),
    .we    (w_ram_we),
    .re    (w_ram_re),
    .wdata (w_ram_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_endp   <= '0;
      r_rcnt   <= 2'd0;
      r_dphase <= c_PH_ISSUE;
      r_err    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, LOAD: begin
          if (w_load_fire) begin
            if (loadLast) begin
              r_state <= RUN;
              r_cnt   <= '0;
            end else if (r_cnt == c_LAST_ADDR) begin
              r_err   <= 1'b1;
              r_state <= RUN;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= LOAD;
            end
          end
        end
        RUN: begin
          if (done) begin
            r_state <= RANGE;
            r_rcnt  <= 2'd0;
          end
        end
        RANGE: begin
          r_rcnt <= r_rcnt + 1'b1;
          if (r_rcnt == 2'd1) begin
            r_ptr <= w_lane0_addr;
          end
          if (r_rcnt == 2'd2) begin
            r_endp <= w_lane0_addr;
            r_rcnt <= 2'd0;
            if (w_lane0_addr < r_ptr) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state  <= DUMP;
              r_dphase <= c_PH_ISSUE;
`ifdef DUMP_CHECKSUM_EN
              r_csum   <= '0;
`endif
            end
          end
        end
        DUMP: begin
          case (r_dphase)
            c_PH_ISSUE: r_dphase <= c_PH_DATA;
            c_PH_DATA: begin
              if (dumpReady) begin
`ifdef DUMP_CHECKSUM_EN
                r_csum <= r_csum ^ w_rdata;
`endif
                if (r_ptr == r_endp) begin
`ifdef DUMP_CHECKSUM_EN
                  r_dphase <= c_PH_CSUM;
`else
                  r_state  <= IDLE;
                  r_dphase <= c_PH_ISSUE;
`endif
                end else begin
                  r_ptr    <= r_ptr + 1'b1;
                  r_dphase <= c_PH_ISSUE;
                end
              end
            end
`ifdef DUMP_CHECKSUM_EN
            c_PH_CSUM: begin
              if (dumpReady) begin
                r_state  <= IDLE;
                r_dphase <= c_PH_ISSUE;
              end
            end
`endif
            default: r_dphase <= c_PH_ISSUE;
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ProcessorDataIn = w_rdata;
  assign start           = (r_state == RUN);
  assign busyLoad        = (r_state == LOAD);
  assign busyRun         = (r_state == RUN);
  assign busyDump        = (r_state == RANGE) || (r_state == DUMP);
  assign err             = r_err;
  assign dumpValid       = (r_state == DUMP) && (r_dphase != c_PH_ISSUE);

`ifdef DUMP_CHECKSUM_EN
  assign dumpLast = (r_state == DUMP) && (r_dphase == c_PH_CSUM);
  assign dumpData = (r_dphase == c_PH_CSUM) ? r_csum : w_rdata;
`else
  assign dumpLast = (r_state == DUMP) && (r_dphase == c_PH_DATA) && (r_ptr == r_endp);
  assign dumpData = w_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int W  = DMEM_REG_WIDTH * DMEM_CORE_COUNT;
  localparam int AW = $clog2(DMEM_DEPTH);

  localparam logic [W-1:0]  WORD_A = 48'h1234_5678_9ABC;
  localparam logic [W-1:0]  OLD_B  = 48'h0BBB_0000_1111;
  localparam logic [W-1:0]  NEW_B  = 48'hFEDC_BA98_7654;
  localparam logic [W-1:0]  WORD_C = 48'h0CCC_2222_3333;
  localparam logic [AW-1:0] ADDR_A = 12'h00A;
  localparam logic [AW-1:0] ADDR_B = 12'h00B;
  localparam logic [AW-1:0] ADDR_C = 12'h00C;
`ifdef DUMP_CHECKSUM_EN
  localparam int EXP_BEATS = 4;
`else
  localparam int EXP_BEATS = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] dataMemAddr = '0;
  logic          DataMemWrEn = 1'b0;
  logic [W-1:0]  ProcessorDataOut = '0;
  logic [W-1:0]  ProcessorDataIn;
  logic          done = 1'b0;
  logic          start;
  logic          loadValid = 1'b0;
  logic          loadReady;
  logic          loadLast = 1'b0;
  logic [W-1:0]  loadData = '0;
  logic          dumpValid;
  logic          dumpReady = 1'b0;
  logic          dumpLast;
  logic [W-1:0]  dumpData;
  logic          busyLoad, busyRun, busyDump, err;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] beats [8];
  logic         lasts [8];
  int           nbeats;
  int           unstable;
  int           stalls;
  bit           got_last;
  logic [W-1:0] exp_beats [4];

  data_mem_responder dut (
    .clk              (clk),
    .rst              (rst),
    .dataMemAddr      (dataMemAddr),
    .DataMemWrEn      (DataMemWrEn),
    .ProcessorDataOut (ProcessorDataOut),
    .ProcessorDataIn  (ProcessorDataIn),
    .done             (done),
    .start            (start),
    .loadValid        (loadValid),
    .loadReady        (loadReady),
    .loadLast         (loadLast),
    .loadData         (loadData),
    .dumpValid        (dumpValid),
    .dumpReady        (dumpReady),
    .dumpLast         (dumpLast),
    .dumpData         (dumpData),
    .busyLoad         (busyLoad),
    .busyRun          (busyRun),
    .busyDump         (busyDump),
    .err              (err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] img(input int k, input logic [11:0] rend);
    logic [11:0] l0;
    l0 = (k == 5) ? 12'h00A : ((k == 8) ? rend : 12'(k));
    return {12'(12'hA00 + k), 12'(12'hB00 + k), 12'(12'hC00 + k), l0};
  endfunction

  task automatic load_image(input logic [11:0] rend);
    for (int k = 0; k < 9; k++) begin
      loadValid = 1'b1;
      loadData  = img(k, rend);
      loadLast  = (k == 8);
      @(posedge clk); #1;
    end
    loadValid = 1'b0;
    loadLast  = 1'b0;
  endtask

  task automatic proc_cycle(input logic [AW-1:0] a, input logic we, input logic [W-1:0] d);
    dataMemAddr      = a;
    DataMemWrEn      = we;
    ProcessorDataOut = d;
    @(posedge clk); #1;
    DataMemWrEn = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic collect_dump(input bit toggle, input int budget);
    logic         hold;
    logic [W-1:0] hold_data;
    hold = 1'b0;
    hold_data = '0;
    nbeats = 0;
    unstable = 0;
    stalls = 0;
    got_last = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      dumpReady = toggle ? (((cyc / 3) % 2) == 1) : 1'b1;
      if (hold && !(dumpValid && (dumpData === hold_data))) unstable++;
      if (dumpValid && !dumpReady) stalls++;
      if (dumpValid && dumpReady && (nbeats < 8)) begin
        beats[nbeats] = dumpData;
        lasts[nbeats] = dumpLast;
        nbeats++;
        if (dumpLast) got_last = 1'b1;
      end
      hold      = dumpValid && !dumpReady;
      hold_data = dumpData;
      @(posedge clk); #1;
      if (got_last) break;
    end
    dumpReady = 1'b0;
  endtask

  task automatic check_dump_beats(input string tag);
    n_vec++;
    if (!got_last) begin
      n_err++;
      $display("FAIL %s_timeout: no dumpLast beat seen, got %0d beats", tag, nbeats);
    end
    n_vec++;
    if (nbeats != EXP_BEATS) begin
      n_err++;
      $display("FAIL %s_count: got %0d beats, expected %0d", tag, nbeats, EXP_BEATS);
    end
    for (int i = 0; i < EXP_BEATS; i++) begin
      if (i < nbeats) begin
        n_vec++;
        if (beats[i] !== exp_beats[i] || lasts[i] !== (i == EXP_BEATS - 1)) begin
          n_err++;
          $display("FAIL %s_beat%0d: got data %h last %b, expected data %h last %b",
                   tag, i, beats[i], lasts[i], exp_beats[i], (i == EXP_BEATS - 1));
        end
      end
    end
    n_vec++;
    if (busyDump !== 1'b0 || loadReady !== 1'b1) begin
      n_err++;
      $display("FAIL %s_idle: got busyDump %b loadReady %b, expected 0 1", tag, busyDump, loadReady);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({start, busyLoad, busyRun, busyDump, err, dumpValid, dumpLast} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, expected 0000000",
               {start, busyLoad, busyRun, busyDump, err, dumpValid, dumpLast});
    end
    n_vec++;
    if (ProcessorDataIn !== '0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h, expected 0", ProcessorDataIn);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (loadReady !== 1'b1) begin
      n_err++;
      $display("FAIL reset_loadready: got %b, expected 1", loadReady);
    end
  endtask

  task automatic test_load();
    for (int k = 0; k < 9; k++) begin
      loadValid = 1'b1;
      loadData  = img(k, 12'h00C);
      loadLast  = (k == 8);
      if (k == 1) begin
        n_vec++;
        if (busyLoad !== 1'b1 || busyRun !== 1'b0) begin
          n_err++;
          $display("FAIL load_busy: got busyLoad %b busyRun %b, expected 1 0", busyLoad, busyRun);
        end
      end
      @(posedge clk); #1;
    end
    loadValid = 1'b0;
    loadLast  = 1'b0;
    n_vec++;
    if (busyRun !== 1'b1 || start !== 1'b1 || busyLoad !== 1'b0 || loadReady !== 1'b0) begin
      n_err++;
      $display("FAIL load_to_run: got busyRun %b start %b busyLoad %b loadReady %b, expected 1 1 0 0",
               busyRun, start, busyLoad, loadReady);
    end
  endtask

  task automatic test_run();
    proc_cycle(ADDR_A, 1'b1, WORD_A);
    proc_cycle(ADDR_B, 1'b1, OLD_B);
    proc_cycle(ADDR_C, 1'b1, WORD_C);
    proc_cycle(ADDR_A, 1'b0, '0);
    n_vec++;
    if (ProcessorDataIn !== WORD_A) begin
      n_err++;
      $display("FAIL run_read_a: got %h, expected %h", ProcessorDataIn, WORD_A);
    end
    proc_cycle(12'd5, 1'b0, '0);
    n_vec++;
    if (ProcessorDataIn !== img(5, 12'h00C)) begin
      n_err++;
      $display("FAIL run_read_word5: got %h, expected %h", ProcessorDataIn, img(5, 12'h00C));
    end
    proc_cycle(ADDR_B, 1'b1, NEW_B);
    n_vec++;
    if (ProcessorDataIn !== OLD_B) begin
      n_err++;
      $display("FAIL run_rw_same_addr: got %h, expected old %h", ProcessorDataIn, OLD_B);
    end
    proc_cycle(ADDR_B, 1'b0, '0);
    n_vec++;
    if (ProcessorDataIn !== NEW_B) begin
      n_err++;
      $display("FAIL run_read_b_new: got %h, expected %h", ProcessorDataIn, NEW_B);
    end
  endtask

  task automatic test_dump_ready();
    pulse_done();
    n_vec++;
    if (start !== 1'b0 || busyDump !== 1'b1) begin
      n_err++;
      $display("FAIL done_start_drop: got start %b busyDump %b, expected 0 1", start, busyDump);
    end
    collect_dump(1'b0, 40);
    check_dump_beats("dump_ready");
  endtask

  task automatic test_dump_stall();
    load_image(12'h00C);
    pulse_done();
    collect_dump(1'b1, 100);
    check_dump_beats("dump_stall");
    n_vec++;
    if (unstable != 0 || stalls == 0) begin
      n_err++;
      $display("FAIL dump_stall_hold: got %0d unstable cycles over %0d stalls, expected 0 over >0",
               unstable, stalls);
    end
  endtask

  task automatic test_range_error();
    int seen;
    seen = 0;
    load_image(12'h004);
    pulse_done();
    dumpReady = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (dumpValid) seen++;
      @(posedge clk); #1;
    end
    dumpReady = 1'b0;
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL range_err_beats: got %0d valid cycles, expected 0", seen);
    end
    n_vec++;
    if (err !== 1'b1 || busyDump !== 1'b0 || loadReady !== 1'b1) begin
      n_err++;
      $display("FAIL range_err_state: got err %b busyDump %b loadReady %b, expected 1 0 1",
               err, busyDump, loadReady);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit found;
    found = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_clears_err: got %b, expected 0", err);
    end
    load_image(12'h00C);
    pulse_done();
    dumpReady = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (dumpValid) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (!found || dumpData !== WORD_A) begin
      n_err++;
      $display("FAIL rst_dump_beat1: got found %b data %h, expected 1 %h", found, dumpData, WORD_A);
    end
    @(posedge clk); #1;
    dumpReady = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (dumpValid !== 1'b1 || dumpData !== NEW_B) begin
      n_err++;
      $display("FAIL rst_dump_beat2: got valid %b data %h, expected 1 %h", dumpValid, dumpData, NEW_B);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (dumpValid !== 1'b0 || busyDump !== 1'b0 || loadReady !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_dump: got valid %b busyDump %b loadReady %b, expected 0 0 1",
               dumpValid, busyDump, loadReady);
    end
  endtask

  task automatic test_retention();
    load_image(12'h00C);
    proc_cycle(ADDR_A, 1'b0, '0);
    n_vec++;
    if (ProcessorDataIn !== WORD_A) begin
      n_err++;
      $display("FAIL retain_a: got %h, expected %h", ProcessorDataIn, WORD_A);
    end
    proc_cycle(ADDR_C, 1'b0, '0);
    n_vec++;
    if (ProcessorDataIn !== WORD_C) begin
      n_err++;
      $display("FAIL retain_c: got %h, expected %h", ProcessorDataIn, WORD_C);
    end
  endtask

  task automatic test_load_overflow();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < DMEM_DEPTH; k++) begin
      loadValid = 1'b1;
      loadLast  = 1'b0;
      loadData  = {12'h5A5, 24'h0, 12'(k)};
      if (k == DMEM_DEPTH - 1) begin
        n_vec++;
        if (busyLoad !== 1'b1 || busyRun !== 1'b0 || err !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_before_last: got busyLoad %b busyRun %b err %b, expected 1 0 0",
                   busyLoad, busyRun, err);
        end
      end
      @(posedge clk); #1;
    end
    loadValid = 1'b0;
    n_vec++;
    if (busyRun !== 1'b1 || err !== 1'b1 || busyLoad !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_to_run: got busyRun %b err %b busyLoad %b, expected 1 1 0",
               busyRun, err, busyLoad);
    end
    proc_cycle(12'hFFF, 1'b0, '0);
    n_vec++;
    if (ProcessorDataIn !== {12'h5A5, 24'h0, 12'hFFF}) begin
      n_err++;
      $display("FAIL ovf_last_word: got %h, expected %h", ProcessorDataIn, {12'h5A5, 24'h0, 12'hFFF});
    end
    proc_cycle(12'h000, 1'b0, '0);
    n_vec++;
    if (ProcessorDataIn !== {12'h5A5, 24'h0, 12'h000}) begin
      n_err++;
      $display("FAIL ovf_first_word: got %h, expected %h", ProcessorDataIn, {12'h5A5, 24'h0, 12'h000});
    end
  endtask

  initial begin
    exp_beats[0] = WORD_A;
    exp_beats[1] = NEW_B;
    exp_beats[2] = WORD_C;
    exp_beats[3] = WORD_A ^ NEW_B ^ WORD_C;
    test_reset();
    test_load();
    test_run();
    test_dump_ready();
    test_dump_stall();
    test_range_error();
    test_reset_mid_dump();
    test_retention();
    test_load_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
